change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Coin-output end of the vending machine payment path. Accepts a change amount, in rupees, from the vending machine controller when a transaction completes. Breaks the amount into coins greedily: 10, 5, 2, then 1 rupee. Issues coins one at a time to the coin hopper over a valid/ready handshake, tracks per-denomination hopper inventory, and reports any amount it could not pay.

Parameters:
CNT_W, 8, width of each per-denomination inventory counter
INIT_COUNT, 20, inventory value loaded into every denomination counter on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
change_valid  input  1  one-cycle request strobe from the vending machine; change_amount is sampled with it
change_amount  input  7  change to pay, 0..127 rupees
busy  output  1  high from acceptance until done is pulsed
coin_valid  output  1  coin request to the hopper
coin_denom  output  2  coin code: 0=1, 1=2, 2=5, 3=10 rupees
coin_ready  input  1  hopper acknowledge; a coin is ejected on cycles where coin_valid and coin_ready are both high
done  output  1  one-cycle pulse at the end of the request
short  output  1  valid with done; high if the amount was not fully paid
shortfall  output  7  valid with done; rupees left unpaid, 0 if short=0
refill_valid  input  1  inventory top-up strobe
refill_denom  input  2  denomination to top up
refill_qty  input  CNT_W  number of coins added
inv_10, inv_5, inv_2, inv_1  output  CNT_W each  current inventory per denomination

Behaviour:
- Reset: asynchronous, active-high. State=IDLE, remaining=0, all inventories=INIT_COUNT. Outputs: busy=0, coin_valid=0, coin_denom=0, done=0, short=0, shortfall=0.
- Reset mid-operation aborts the request immediately. No done pulse. The coin in flight is not counted.
- FSM states: IDLE, SELECT, ISSUE, FINISH.
- IDLE:
  - On change_valid, latch remaining=change_amount and go to SELECT; busy=1 from the next cycle.
  - change_valid while busy is ignored, with no queueing.
- SELECT (one cycle): pick the largest denomination d with value(d) <= remaining and inv_d > 0.
  - remaining==0 -> FINISH with short=0.
  - No denomination qualifies -> FINISH with short=1, shortfall=remaining.
  - Otherwise register coin_denom=d and go to ISSUE.
- ISSUE:
  - coin_valid=1. coin_denom stays stable until the handshake.
  - On coin_valid & coin_ready: remaining -= value(d), inv_d -= 1, coin_valid drops the next cycle, return to SELECT.
  - Minimum coin spacing is therefore 2 cycles.
- FINISH (one cycle):
  - done=1; short and shortfall are valid in the same cycle.
  - busy is still 1 in this cycle and clears on the next edge, with return to IDLE.
  - short and shortfall hold their value until the next request's FINISH.
- Latency:
  - change_amount=0: done asserts 2 cycles after the change_valid edge.
  - First coin_valid: 2 cycles after change_valid.
- Arithmetic:
  - remaining never underflows, because selection guarantees value(d) <= remaining.
  - Greedy order is fixed. When inventory is exhausted, the next lower denomination is used, and the remaining amount is re-evaluated each SELECT.
- Refill:
  - Accepted in any state, applied at the clock edge.
  - inv = inv + refill_qty, saturating at 2^CNT_W - 1.
  - A refill of the same denomination as a simultaneous handshake decrement nets both: inv + qty - 1, saturating. The decrement is always honoured.
  - A refill during SELECT affects the next SELECT evaluation, not the current one.
- Inventory never goes below 0. A denomination with inv=0 is never selected.

Test Plan:
1. Reset, change_valid with change_amount=18, coin_ready tied high -> coins 10,5,2,1 in order, done with short=0, inv_10=19 and inv_5, inv_2, inv_1 each 19.
2. change_amount=0 -> no coin_valid; done 2 cycles after the strobe, short=0, shortfall=0.
3. Drain inv_10 to 0, then change_amount=20 -> four 5-rupee coins, inv_5 decreases by 4, short=0.
4. Force all inventories to 0 via reset with INIT_COUNT=0, change_amount=3 -> no coins, done with short=1, shortfall=3. Then refill 1-rupee coins with qty=5 and request 3 again -> three 1-rupee coins, inv_1=2.
5. change_amount=10 with coin_ready held low for 5 cycles -> coin_valid=1 and coin_denom=3 stable throughout; exactly one coin on the ready cycle. A change_valid pulsed during that wait is ignored.
6. Assert reset during ISSUE of change_amount=17 -> all outputs return to reset values at once, inventories=INIT_COUNT, and no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: splits a change amount into 10/5/2/1 rupee coins,
// issues them to the hopper over valid/ready and keeps per-denomination inventory.
module change_dispenser #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned INIT_COUNT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_valid,
  input  logic [6:0]       change_amount,
  output logic             busy,
  output logic             coin_valid,
  output logic [1:0]       coin_denom,
  input  logic             coin_ready,
  output logic             done,
  output logic             short,
  output logic [6:0]       shortfall,
  input  logic             refill_valid,
  input  logic [1:0]       refill_denom,
  input  logic [CNT_W-1:0] refill_qty,
  output logic [CNT_W-1:0] inv_10,
  output logic [CNT_W-1:0] inv_5,
  output logic [CNT_W-1:0] inv_2,
  output logic [CNT_W-1:0] inv_1
);

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, FINISH} state_t;

  state_t           state;
  logic [6:0]       remaining;
  logic [CNT_W-1:0] inv      [4];
  logic [CNT_W-1:0] inv_next [4];
  logic             sel_found;
  logic [1:0]       sel_denom;
  logic             fire;
  logic [CNT_W:0]   sum;

  function automatic logic [6:0] denom_value(input logic [1:0] d);
    case (d)
      2'd0:    return 7'd1;
      2'd1:    return 7'd2;
      2'd2:    return 7'd5;
      default: return 7'd10;
    endcase
  endfunction

  assign fire   = (state == ISSUE) && coin_valid && coin_ready;
  assign inv_1  = inv[0];
  assign inv_2  = inv[1];
  assign inv_5  = inv[2];
  assign inv_10 = inv[3];

  // Ascending scan: the last qualifying code is the largest denomination.
  always_comb begin
    sel_found = 1'b0;
    sel_denom = 2'd0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (inv[i] != '0 && denom_value(2'(i)) <= remaining) begin
        sel_found = 1'b1;
        sel_denom = 2'(i);
      end
    end
  end

  // Refill and handshake decrement are netted before saturating.
  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      sum = {1'b0, inv[i]};
      if (refill_valid && refill_denom == 2'(i))
        sum = sum + {1'b0, refill_qty};
      if (fire && coin_denom == 2'(i))
        sum = sum - (CNT_W+1)'(1);
      inv_next[i] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      busy       <= 1'b0;
      coin_valid <= 1'b0;
      coin_denom <= '0;
      done       <= 1'b0;
      short      <= 1'b0;
      shortfall  <= '0;
      for (int unsigned i = 0; i < 4; i++)
        inv[i] <= CNT_W'(INIT_COUNT);
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        inv[i] <= inv_next[i];
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (change_valid) begin
            remaining <= change_amount;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (remaining == '0) begin
            short     <= 1'b0;
            shortfall <= '0;
            done      <= 1'b1;
            state     <= FINISH;
          end else if (!sel_found) begin
            short     <= 1'b1;
            shortfall <= remaining;
            done      <= 1'b1;
            state     <= FINISH;
          end else begin
            coin_denom <= sel_denom;
            coin_valid <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (coin_ready) begin
            remaining  <= remaining - denom_value(coin_denom);
            coin_valid <= 1'b0;
            state      <= SELECT;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: one instance with default inventory,
// one with empty inventory for the shortfall path.
module tb_change_dispenser;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic             a_change_valid, a_busy, a_coin_valid, a_coin_ready, a_done, a_short;
  logic [6:0]       a_change_amount, a_shortfall;
  logic [1:0]       a_coin_denom, a_refill_denom;
  logic             a_refill_valid;
  logic [CNT_W-1:0] a_refill_qty, a_inv_10, a_inv_5, a_inv_2, a_inv_1;

  logic             b_change_valid, b_busy, b_coin_valid, b_coin_ready, b_done, b_short;
  logic [6:0]       b_change_amount, b_shortfall;
  logic [1:0]       b_coin_denom, b_refill_denom;
  logic             b_refill_valid;
  logic [CNT_W-1:0] b_refill_qty, b_inv_10, b_inv_5, b_inv_2, b_inv_1;

  change_dispenser #(.CNT_W(CNT_W), .INIT_COUNT(20)) dut_a (
    .clk(clk), .reset(reset),
    .change_valid(a_change_valid), .change_amount(a_change_amount),
    .busy(a_busy), .coin_valid(a_coin_valid), .coin_denom(a_coin_denom),
    .coin_ready(a_coin_ready), .done(a_done), .short(a_short), .shortfall(a_shortfall),
    .refill_valid(a_refill_valid), .refill_denom(a_refill_denom), .refill_qty(a_refill_qty),
    .inv_10(a_inv_10), .inv_5(a_inv_5), .inv_2(a_inv_2), .inv_1(a_inv_1)
  );

  change_dispenser #(.CNT_W(CNT_W), .INIT_COUNT(0)) dut_b (
    .clk(clk), .reset(reset),
    .change_valid(b_change_valid), .change_amount(b_change_amount),
    .busy(b_busy), .coin_valid(b_coin_valid), .coin_denom(b_coin_denom),
    .coin_ready(b_coin_ready), .done(b_done), .short(b_short), .shortfall(b_shortfall),
    .refill_valid(b_refill_valid), .refill_denom(b_refill_denom), .refill_qty(b_refill_qty),
    .inv_10(b_inv_10), .inv_5(b_inv_5), .inv_2(b_inv_2), .inv_1(b_inv_1)
  );

  int errors = 0;
  int checks = 0;
  int a_coins[$];
  int b_coins[$];
  int a_done_cnt = 0;
  bit found;

  // Inputs only change #1 after posedge, so a valid&ready seen here is taken at the next edge.
  always @(negedge clk) begin
    if (!reset && a_coin_valid && a_coin_ready) a_coins.push_back(int'(a_coin_denom));
    if (!reset && b_coin_valid && b_coin_ready) b_coins.push_back(int'(b_coin_denom));
    if (!reset && a_done) a_done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit use_b, input logic [6:0] amt);
    if (use_b) begin
      b_change_valid = 1'b1; b_change_amount = amt;
    end else begin
      a_change_valid = 1'b1; a_change_amount = amt;
    end
    step();
    a_change_valid = 1'b0;
    b_change_valid = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      if (use_b ? b_done : a_done) seen = 1'b1;
      else step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    a_change_valid = 0; a_change_amount = '0; a_coin_ready = 0;
    a_refill_valid = 0; a_refill_denom = '0; a_refill_qty = '0;
    b_change_valid = 0; b_change_amount = '0; b_coin_ready = 0;
    b_refill_valid = 0; b_refill_denom = '0; b_refill_qty = '0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_busy", a_busy, 0);
    check("rst_coin_valid", a_coin_valid, 0);
    check("rst_coin_denom", a_coin_denom, 0);
    check("rst_done", a_done, 0);
    check("rst_short", a_short, 0);
    check("rst_shortfall", a_shortfall, 0);
    check("rst_inv_10", a_inv_10, 20);
    check("rst_b_inv_1", b_inv_1, 0);

    // 18 -> 10,5,2,1
    a_coin_ready = 1'b1;
    request(0, 7'd18);
    check("t1_busy_after_accept", a_busy, 1);
    check("t1_no_coin_yet", a_coin_valid, 0);
    step();
    check("t1_first_coin_valid", a_coin_valid, 1);
    check("t1_first_coin_denom", a_coin_denom, 3);
    wait_done(0, 40, found);
    check("t1_done_seen", found, 1);
    check("t1_short", a_short, 0);
    check("t1_shortfall", a_shortfall, 0);
    check("t1_busy_in_finish", a_busy, 1);
    check("t1_coin_count", a_coins.size(), 4);
    check("t1_coin0", a_coins.size() > 0 ? a_coins[0] : -1, 3);
    check("t1_coin1", a_coins.size() > 1 ? a_coins[1] : -1, 2);
    check("t1_coin2", a_coins.size() > 2 ? a_coins[2] : -1, 1);
    check("t1_coin3", a_coins.size() > 3 ? a_coins[3] : -1, 0);
    check("t1_inv_10", a_inv_10, 19);
    check("t1_inv_5", a_inv_5, 19);
    check("t1_inv_2", a_inv_2, 19);
    check("t1_inv_1", a_inv_1, 19);
    step();
    check("t1_busy_clear", a_busy, 0);
    check("t1_done_pulse_end", a_done, 0);

    // zero amount
    a_coins.delete();
    request(0, 7'd0);
    check("t2_busy", a_busy, 1);
    check("t2_done_early", a_done, 0);
    step();
    check("t2_done", a_done, 1);
    check("t2_short", a_short, 0);
    check("t2_shortfall", a_shortfall, 0);
    check("t2_no_coins", a_coins.size(), 0);
    step();
    check("t2_done_one_cycle", a_done, 0);

    // drain tens: 120 uses 12, 70 uses 7 -> 0 left
    request(0, 7'd120);
    wait_done(0, 60, found);
    check("t3_done_120", found, 1);
    step();
    request(0, 7'd70);
    wait_done(0, 60, found);
    check("t3_done_70", found, 1);
    check("t3_inv_10_empty", a_inv_10, 0);
    step();
    a_coins.delete();
    request(0, 7'd20);
    wait_done(0, 60, found);
    check("t3_done_20", found, 1);
    check("t3_short", a_short, 0);
    check("t3_coin_count", a_coins.size(), 4);
    for (int i = 0; i < 4; i++)
      check("t3_coin_is_5", a_coins.size() > i ? a_coins[i] : -1, 2);
    check("t3_inv_5", a_inv_5, 15);
    step();

    // refill saturation
    a_refill_valid = 1'b1; a_refill_denom = 2'd0; a_refill_qty = 8'd255;
    step();
    a_refill_valid = 1'b0;
    check("sat_inv_1", a_inv_1, 255);

    // empty inventory instance
    b_coin_ready = 1'b1;
    request(1, 7'd3);
    step();
    check("t4_done", b_done, 1);
    check("t4_short", b_short, 1);
    check("t4_shortfall", b_shortfall, 3);
    check("t4_no_coins", b_coins.size(), 0);
    step();
    b_refill_valid = 1'b1; b_refill_denom = 2'd0; b_refill_qty = 8'd5;
    step();
    b_refill_valid = 1'b0;
    check("t4_refill_inv_1", b_inv_1, 5);
    request(1, 7'd3);
    wait_done(1, 30, found);
    check("t4_done2", found, 1);
    check("t4_short2", b_short, 0);
    check("t4_shortfall2", b_shortfall, 0);
    check("t4_coin_count", b_coins.size(), 3);
    for (int i = 0; i < 3; i++)
      check("t4_coin_is_1", b_coins.size() > i ? b_coins[i] : -1, 0);
    check("t4_inv_1", b_inv_1, 2);
    step();

    // held-off hopper; stray request ignored; refill nets with decrement
    a_refill_valid = 1'b1; a_refill_denom = 2'd3; a_refill_qty = 8'd3;
    step();
    a_refill_valid = 1'b0;
    check("t5_refill_inv_10", a_inv_10, 3);
    a_coin_ready = 1'b0;
    a_coins.delete();
    request(0, 7'd10);
    step();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", a_coin_valid, 1);
      check("t5_hold_denom", a_coin_denom, 3);
      if (i == 1) begin
        a_change_valid = 1'b1; a_change_amount = 7'd50;
      end
      step();
      a_change_valid = 1'b0;
    end
    a_coin_ready = 1'b1;
    a_refill_valid = 1'b1; a_refill_denom = 2'd3; a_refill_qty = 8'd1;
    step();
    a_refill_valid = 1'b0;
    check("t5_valid_drops", a_coin_valid, 0);
    check("t5_inv_10_netted", a_inv_10, 3);
    wait_done(0, 20, found);
    check("t5_done", found, 1);
    check("t5_short", a_short, 0);
    check("t5_coin_count", a_coins.size(), 1);
    check("t5_coin_denom", a_coins.size() > 0 ? a_coins[0] : -1, 3);
    repeat (4) step();
    check("t5_stray_ignored_busy", a_busy, 0);
    check("t5_stray_ignored_coins", a_coins.size(), 1);

    // reset during ISSUE
    a_coin_ready = 1'b0;
    a_coins.delete();
    a_done_cnt = 0;
    request(0, 7'd17);
    step();
    check("t6_in_issue", a_coin_valid, 1);
    reset = 1'b1;
    #1;
    check("t6_busy", a_busy, 0);
    check("t6_coin_valid", a_coin_valid, 0);
    check("t6_coin_denom", a_coin_denom, 0);
    check("t6_done", a_done, 0);
    check("t6_short", a_short, 0);
    check("t6_shortfall", a_shortfall, 0);
    check("t6_inv_10", a_inv_10, 20);
    check("t6_inv_5", a_inv_5, 20);
    check("t6_inv_2", a_inv_2, 20);
    check("t6_inv_1", a_inv_1, 20);
    a_coin_ready = 1'b1;
    step();
    reset = 1'b0;
    repeat (6) step();
    check("t6_no_done", a_done_cnt, 0);
    check("t6_no_coins", a_coins.size(), 0);
    check("t6_idle", a_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
